// File: rtl/noc_link_flit_receiver.sv
// -----------------------------------------------------------------------------
// noc_link_flit_receiver
//
// Terminates one credit-based router output link in the clk_noc domain. Incoming
// flits are buffered in a small FIFO. Each flit consumed from the FIFO returns
// one credit to the sender. SERIALIZATION_FACTOR flits are reassembled into one
// AXI-Stream beat, with flit 0 in the LSBs.
//
// Optional feature macro: NOC_LINK_RX_STATS_EN
//   When defined, the stat_flits and stat_pkts saturating counters and their
//   ports are added.
//
// Ports
//   clk_noc         link clock (the only clock)
//   rst_n           asynchronous reset, active-low
//   data_in         flit payload
//   dest_in         destination carried on every flit
//   is_tail_in      last flit of the packet
//   send_in         flit valid (at most one flit per cycle)
//   credit_out      one-cycle pulse per freed buffer slot
//   axis_tvalid     beat valid
//   axis_tready     beat accepted
//   axis_tdata      assembled beat (flit 0 in the LSBs)
//   axis_tlast      is_tail of the beat's final flit
//   axis_tdest      dest of the beat's final flit
//   err_overflow    sticky: a flit arrived while the FIFO was full
//   err_tail_align  sticky: is_tail seen on a flit that does not end a beat
//   stat_flits      (NOC_LINK_RX_STATS_EN) accepted flit writes, saturating
//   stat_pkts       (NOC_LINK_RX_STATS_EN) accepted beats with tlast, saturating
// -----------------------------------------------------------------------------
module noc_link_flit_receiver #(
  parameter  int FLIT_WIDTH           = 64,
  parameter  int DEST_WIDTH           = 4,
  parameter  int SERIALIZATION_FACTOR = 1,
  parameter  int BUFFER_DEPTH         = 2,
  localparam int TDATA_WIDTH          = FLIT_WIDTH * SERIALIZATION_FACTOR
) (
  input  logic                   clk_noc,
  input  logic                   rst_n,
  input  logic [FLIT_WIDTH-1:0]  data_in,
  input  logic [DEST_WIDTH-1:0]  dest_in,
  input  logic                   is_tail_in,
  input  logic                   send_in,
  output logic                   credit_out,
  output logic                   axis_tvalid,
  input  logic                   axis_tready,
  output logic [TDATA_WIDTH-1:0] axis_tdata,
  output logic                   axis_tlast,
  output logic [DEST_WIDTH-1:0]  axis_tdest,
  output logic                   err_overflow,
  output logic                   err_tail_align
`ifdef NOC_LINK_RX_STATS_EN
  ,
  output logic [31:0]            stat_flits,
  output logic [31:0]            stat_pkts
`endif
);

  localparam int ENTRY_W = FLIT_WIDTH + DEST_WIDTH + 1;
  localparam int PTR_W   = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int CNT_W   = $clog2(BUFFER_DEPTH + 1);
  localparam int IDX_W   = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUFFER_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUFFER_DEPTH - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SERIALIZATION_FACTOR - 1);

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_OUTPUT  = 1'b1
  } state_t;

  state_t                  state_r;
  logic [IDX_W-1:0]        idx_r;
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]        count_r;
  logic [ENTRY_W-1:0]      mem_r [BUFFER_DEPTH];

  logic                    fifo_empty_s;
  logic                    fifo_full_s;
  logic                    pop_s;
  logic                    push_s;
  logic                    drop_s;
  logic [ENTRY_W-1:0]      rd_entry_s;
  logic [FLIT_WIDTH-1:0]   rd_data_s;
  logic [DEST_WIDTH-1:0]   rd_dest_s;
  logic                    rd_tail_s;

  // Pointers wrap modulo BUFFER_DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    if (ptr == PTR_LAST) begin
      nxt = {PTR_W{1'b0}};
    end else begin
      nxt = ptr + PTR_W'(1);
    end
    return nxt;
  endfunction

  // FIFO status and push/pop decisions. A push into a full FIFO is still
  // accepted when a pop happens in the same cycle.
  always_comb begin
    fifo_empty_s = (count_r == {CNT_W{1'b0}});
    fifo_full_s  = (count_r == CNT_FULL);
    pop_s        = (state_r == ST_COLLECT) && !fifo_empty_s;
    push_s       = send_in && (!fifo_full_s || pop_s);
    drop_s       = send_in && fifo_full_s && !pop_s;
    rd_entry_s   = mem_r[rd_ptr_r];
    rd_data_s    = rd_entry_s[ENTRY_W-1 -: FLIT_WIDTH];
    rd_dest_s    = rd_entry_s[DEST_WIDTH:1];
    rd_tail_s    = rd_entry_s[0];
  end

  // FIFO storage: payload only, so no reset is needed.
  always_ff @(posedge clk_noc) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {data_in, dest_in, is_tail_in};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Beat assembly FSM with registered AXIS outputs, credit return and tail check.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_COLLECT;
      idx_r          <= {IDX_W{1'b0}};
      credit_out     <= 1'b0;
      axis_tvalid    <= 1'b0;
      axis_tdata     <= {TDATA_WIDTH{1'b0}};
      axis_tlast     <= 1'b0;
      axis_tdest     <= {DEST_WIDTH{1'b0}};
      err_tail_align <= 1'b0;
    end else begin
      credit_out <= pop_s;
      case (state_r)
        ST_COLLECT: begin
          if (pop_s) begin
            for (int s = 0; s < SERIALIZATION_FACTOR; s++) begin
              if (idx_r == IDX_W'(s)) begin
                axis_tdata[s*FLIT_WIDTH +: FLIT_WIDTH] <= rd_data_s;
              end
            end
            if (idx_r == IDX_LAST) begin
              axis_tdest  <= rd_dest_s;
              axis_tlast  <= rd_tail_s;
              idx_r       <= {IDX_W{1'b0}};
              axis_tvalid <= 1'b1;
              state_r     <= ST_OUTPUT;
            end else begin
              // A tail here ends the packet mid-beat; flag it but keep assembling.
              if (rd_tail_s) begin
                err_tail_align <= 1'b1;
              end
              idx_r <= idx_r + IDX_W'(1);
            end
          end
        end
        ST_OUTPUT: begin
          if (axis_tready) begin
            axis_tvalid <= 1'b0;
            state_r     <= ST_COLLECT;
          end
        end
        default: begin
          axis_tvalid <= 1'b0;
          state_r     <= ST_COLLECT;
        end
      endcase
    end
  end

  // Sticky overflow flag: a flit was dropped because the FIFO was full.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow <= 1'b0;
    end else if (drop_s) begin
      err_overflow <= 1'b1;
    end
  end

`ifdef NOC_LINK_RX_STATS_EN
  // Saturating link statistics: accepted flits and accepted tail beats.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      stat_flits <= 32'd0;
      stat_pkts  <= 32'd0;
    end else begin
      if (push_s && (stat_flits != 32'hFFFF_FFFF)) begin
        stat_flits <= stat_flits + 32'd1;
      end
      if (axis_tvalid && axis_tready && axis_tlast && (stat_pkts != 32'hFFFF_FFFF)) begin
        stat_pkts <= stat_pkts + 32'd1;
      end
    end
  end
`endif

endmodule
